// File: rtl/jogador_automatico_if.sv
// Signal bundle between the game and the automatic player.
// Handshake: there is no valid/ready pair. Every input is a level sampled on
// the rising clock edge, and every output is a level that holds until the
// player changes it; fim is the only pulse and lasts exactly one cycle.
interface jogador_automatico_if;
  logic       iniciar;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
  logic       erro_en;
  logic [3:0] erro_idx;
  logic [3:0] botoes;
  logic       ocupado;
  logic       fim;
  logic [4:0] capturados;
  logic       overflow;
  logic [3:0] db_estado;

  // Game / stimulus side
  modport master (
    output iniciar, leds, ganhou, perdeu, erro_en, erro_idx,
    input  botoes, ocupado, fim, capturados, overflow, db_estado
  );

  // Player side
  modport slave (
    input  iniciar, leds, ganhou, perdeu, erro_en, erro_idx,
    output botoes, ocupado, fim, capturados, overflow, db_estado
  );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic player: records the LED sequence the game shows, then replays it
// on the buttons with fixed press/release timing. An optional fault injects
// one wrong press at a chosen buffer position.
module jogador_automatico #(
  parameter int T_PRESS = 100,
  parameter int T_SOLTA = 100,
  parameter int T_GAP   = 50
) (
  input logic                   clock,
  input logic                   reset,
  jogador_automatico_if.slave   jif
);

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    ESPERA_LED = 4'd1,
    CAPTURA    = 4'd2,
    ENTRE      = 4'd3,
    PRESS      = 4'd4,
    SOLTA      = 4'd5,
    PARADO     = 4'd6
  } estado_t;

  // Phase counters hold 0..T-1, so 16 bits cover parameters up to 65535.
  localparam logic [15:0] PRESS_LAST = 16'(T_PRESS - 1);
  localparam logic [15:0] SOLTA_LAST = 16'(T_SOLTA - 1);
  localparam logic [15:0] GAP_LAST   = 16'(T_GAP - 1);

  estado_t     estado, estado_d;
  logic [3:0]  botoes_q, botoes_d;
  logic        fim_q, fim_d;
  logic [4:0]  capt_q, capt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] fase_q, fase_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  leds_prev;
  logic [3:0]  mem [16];

  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        store;
  logic [3:0]  rep_idx;
  logic [3:0]  rep_raw;
  logic [3:0]  rep_val;

  // Value of the next press: first item when leaving ENTRE, next item when
  // leaving SOLTA; the chosen error position is rotated left by one.
  always_comb begin
    rep_idx = (estado == SOLTA) ? idx_q + 4'd1 : 4'd0;
    rep_raw = mem[rep_idx];
    rep_val = rep_raw;
    if (jif.erro_en && (jif.erro_idx == rep_idx))
      rep_val = {rep_raw[2:0], rep_raw[3]};
  end

  // Next-state, next-output and capture control.
  always_comb begin
    estado_d = estado;
    botoes_d = 4'd0;
    fim_d    = 1'b0;
    capt_d   = capt_q;
    ovf_d    = ovf_q;
    gap_d    = gap_q;
    fase_d   = fase_q;
    idx_d    = idx_q;
    wr_en    = 1'b0;
    wr_addr  = capt_q[3:0];
    store    = 1'b0;

    if ((jif.ganhou || jif.perdeu) && (estado != OCIOSO)) begin
      // Game end overrides everything and silences the buttons.
      estado_d = PARADO;
      gap_d    = 16'd0;
      fase_d   = 16'd0;
    end else begin
      case (estado)
        OCIOSO, PARADO: begin
          if (jif.iniciar) estado_d = ESPERA_LED;
        end
        ESPERA_LED: begin
          if (jif.leds != 4'd0) begin
            // A new burst restarts the buffer at address 0.
            estado_d = CAPTURA;
            wr_en    = 1'b1;
            wr_addr  = 4'd0;
            capt_d   = 5'd1;
          end
        end
        CAPTURA: begin
          if (jif.leds == 4'd0) begin
            estado_d = ENTRE;
            gap_d    = 16'd1;
          end else if (jif.leds != leds_prev) begin
            store = 1'b1;
          end
        end
        ENTRE: begin
          if (jif.leds != 4'd0) begin
            store    = 1'b1;
            estado_d = CAPTURA;
            gap_d    = 16'd0;
          end else if (gap_q >= GAP_LAST) begin
            estado_d = PRESS;
            idx_d    = 4'd0;
            fase_d   = 16'd0;
            botoes_d = rep_val;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        PRESS: begin
          if (fase_q == PRESS_LAST) begin
            estado_d = SOLTA;
            fase_d   = 16'd0;
          end else begin
            fase_d   = fase_q + 16'd1;
            botoes_d = botoes_q;
          end
        end
        SOLTA: begin
          if (fase_q == SOLTA_LAST) begin
            fase_d = 16'd0;
            if ({1'b0, idx_q} < (capt_q - 5'd1)) begin
              estado_d = PRESS;
              idx_d    = idx_q + 4'd1;
              botoes_d = rep_val;
            end else begin
              estado_d = ESPERA_LED;
              fim_d    = 1'b1;
            end
          end else begin
            fase_d = fase_q + 16'd1;
          end
        end
        default: estado_d = OCIOSO;
      endcase
    end

    // A full buffer drops further items and flags the loss.
    if (store) begin
      if (capt_q == 5'd16) begin
        ovf_d = 1'b1;
      end else begin
        wr_en  = 1'b1;
        capt_d = capt_q + 5'd1;
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      botoes_q  <= 4'd0;
      fim_q     <= 1'b0;
      capt_q    <= 5'd0;
      ovf_q     <= 1'b0;
      gap_q     <= 16'd0;
      fase_q    <= 16'd0;
      idx_q     <= 4'd0;
      leds_prev <= 4'd0;
    end else begin
      estado    <= estado_d;
      botoes_q  <= botoes_d;
      fim_q     <= fim_d;
      capt_q    <= capt_d;
      ovf_q     <= ovf_d;
      gap_q     <= gap_d;
      fase_q    <= fase_d;
      idx_q     <= idx_d;
      leds_prev <= jif.leds;
    end
  end

  // Capture buffer; contents only matter once capturados says they are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= jif.leds;
  end

  assign jif.botoes     = botoes_q;
  assign jif.fim        = fim_q;
  assign jif.capturados = capt_q;
  assign jif.overflow   = ovf_q;
  assign jif.db_estado  = estado;
  assign jif.ocupado    = (estado != OCIOSO) && (estado != PARADO);

endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter T_PRESS, default 100: clock cycles each replayed button stays pressed.
REQ-002 Parameter T_SOLTA, default 100: clock cycles of all-zero botoes after each press.
REQ-003 Parameter T_GAP, default 50: consecutive cycles of leds==0 that end a display burst.
REQ-004 clock  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 iniciar  input  1  level; starts the player from OCIOSO or PARADO.
REQ-007 leds  input  4  game LED output, the sequence being displayed.
REQ-008 ganhou, perdeu  input  1 each  game end flags.
REQ-009 erro_en  input  1  enables deliberate wrong play.
REQ-010 erro_idx  input  4  buffer index replayed wrongly when erro_en=1.
REQ-011 botoes  output  4  button stimulus to the game.
REQ-012 ocupado  output  1  high in every state except OCIOSO and PARADO.
REQ-013 fim  output  1  one-cycle pulse after the last release of a replay.
REQ-014 capturados  output  5  number of items in the buffer, 0..16.
REQ-015 overflow  output  1  sticky; set when a 17th item is seen in one burst.
REQ-016 db_estado  output  4  state code for the 7-segment debug display.

Function
REQ-017 States and codes: OCIOSO=0, ESPERA_LED=1, CAPTURA=2, ENTRE=3, PRESS=4, SOLTA=5, PARADO=6.
REQ-018 OCIOSO/PARADO + iniciar=1 -> ESPERA_LED; iniciar is ignored in all other states.
REQ-019 ESPERA_LED + leds!=0 -> CAPTURA; on that edge clear the buffer, store leds at address 0, set capturados=1.
REQ-020 CAPTURA + leds==0 -> ENTRE with gap counter=1.
REQ-021 CAPTURA + leds nonzero and different from the previous sample -> store as a new item and stay in CAPTURA.
REQ-022 ENTRE + leds!=0 -> store as a new item, go to CAPTURA, and clear the gap counter.
REQ-023 ENTRE + gap counter reaching T_GAP -> PRESS with replay index=0.
REQ-024 leds values are stored unmodified; values that are not one-hot are accepted as-is.
REQ-025 Buffer is 16x4; items seen while capturados==16 are discarded, overflow is set, and capturados stays at 16.
REQ-026 PRESS: botoes=buffer[index] for exactly T_PRESS cycles, then -> SOLTA.
REQ-027 SOLTA: botoes=0 for exactly T_SOLTA cycles; then, if index<capturados-1, increment index and go to PRESS.
REQ-028 SOLTA end with index==capturados-1: fim=1 for one cycle and -> ESPERA_LED.
REQ-029 When erro_en=1 and index==erro_idx, PRESS drives buffer[index] rotated left by 1 (0001->0010, 1000->0001).
REQ-030 An erro_idx value of capturados or more has no effect.
REQ-031 Either ganhou or perdeu at 1 in any state except OCIOSO -> PARADO on the next edge.
REQ-032 PARADO forces botoes=0; ganhou/perdeu has priority over every other transition.
REQ-033 botoes is registered and is 0 in every state other than PRESS.
REQ-034 Counters are wide enough for parameter values up to 65535 and never wrap inside a phase.

Reset
REQ-035 reset=1 forces, immediately and without waiting for clock: state OCIOSO, botoes=0, ocupado=0, fim=0, capturados=0, overflow=0, counters=0.
REQ-036 A reset asserted mid-press drops botoes to 0 at once, and the buffer contents are not used afterwards.
REQ-037 overflow clears only on reset.

Verification
REQ-038 Scenario: reset, iniciar pulse, leds=0001 for 10 cycles, then 0 for 60 cycles -> capturados=1, botoes=0001 for 100 cycles, 0 for 100 cycles, fim pulse, db_estado=1.
REQ-039 Scenario: burst 0001,0010,0100,1000 (10 cycles on, 10 off each) -> replay of the same 4 values in order, each with 100/100 timing.
REQ-040 Scenario: same burst with erro_en=1 and erro_idx=2 -> third press is 1000 and all other presses are correct.
REQ-041 Scenario: 17-item burst -> capturados=16, overflow=1, and 16 presses replayed.
REQ-042 Scenario: perdeu=1 during a PRESS -> next cycle botoes=0, db_estado=6, ocupado=0; iniciar=1 -> db_estado=1.
REQ-043 Scenario: reset asserted between clock edges during PRESS -> botoes=0 and capturados=0 before the next edge.
